// File: rtl/hwpf_stride_req_gen_if.sv
// hwpf_stride_req_gen_if
//   Prefetch request channel between the stride request generator (master)
//   and the prefetch request consumer (slave).
//   Signals:
//     req_valid  master->slave  request valid
//     req_ready  slave->master  request accepted
//     req_nline  master->slave  cache line to prefetch
interface hwpf_stride_req_gen_if #(
  parameter int unsigned NLINE_W = 26
);
  logic               req_valid;
  logic               req_ready;
  logic [NLINE_W-1:0] req_nline;

  modport master (
    output req_valid,
    output req_nline,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_nline,
    output req_ready
  );
endinterface

// File: rtl/hwpf_stride_req_gen.sv
// hwpf_stride_req_gen
//   Stride prefetch request generator. Holds the base cache line watched by
//   the stride snooper and drives its enable. On a snoop match it issues a
//   burst of cfg_nlines_i requests at base + k*stride (k = 1..N) over the
//   req_if valid/ready channel, then either rearms at the last issued line
//   or returns to IDLE.
//
//   Build option: define HPDCACHE_HWPF_STRIDE_NEGATIVE_EN to treat
//   cfg_stride_i as two's complement (sign-extended); otherwise it is
//   unsigned (zero-extended).
//
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     en_i              engine enable; low forces IDLE
//     cfg_base_set_i    load cfg_base_i as base and arm
//     cfg_base_i        new base cache line
//     cfg_stride_i      stride in cache lines
//     cfg_nlines_i      lines per trigger (0 = matches ignored)
//     cfg_rearm_i       after a burst: 1 = rearm at last line, 0 = IDLE
//     snoop_match_i     match from snooper
//     snoop_en_o        snooper enable
//     base_nline_o      base line for the snooper
//     req_if            prefetch request channel (master side)
//     busy_o            burst in progress
module hwpf_stride_req_gen #(
  parameter int unsigned STRIDE_W = 16,
  parameter int unsigned NLINES_W = 4,
  parameter int unsigned NLINE_W  = 26
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                cfg_base_set_i,
  input  logic [NLINE_W-1:0]  cfg_base_i,
  input  logic [STRIDE_W-1:0] cfg_stride_i,
  input  logic [NLINES_W-1:0] cfg_nlines_i,
  input  logic                cfg_rearm_i,
  input  logic                snoop_match_i,
  output logic                snoop_en_o,
  output logic [NLINE_W-1:0]  base_nline_o,
  hwpf_stride_req_gen_if.master req_if,
  output logic                busy_o
);

  typedef logic [NLINE_W-1:0] hpdcache_nline_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ISSUE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  hpdcache_nline_t     base_q, base_d;
  hpdcache_nline_t     next_nline_q, next_nline_d;
  hpdcache_nline_t     stride_q, stride_d;
  logic [NLINES_W-1:0] nlines_q, nlines_d;
  logic [NLINES_W-1:0] cnt_q, cnt_d;
  logic                rearm_q, rearm_d;

  // Stride widened to the line width; the build option selects the sign rule.
  hpdcache_nline_t     stride_ext;
`ifdef HPDCACHE_HWPF_STRIDE_NEGATIVE_EN
  assign stride_ext = NLINE_W'(signed'(cfg_stride_i));
`else
  assign stride_ext = NLINE_W'(cfg_stride_i);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      base_q       <= '0;
      next_nline_q <= '0;
      stride_q     <= '0;
      nlines_q     <= '0;
      cnt_q        <= '0;
      rearm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      next_nline_q <= next_nline_d;
      stride_q     <= stride_d;
      nlines_q     <= nlines_d;
      cnt_q        <= cnt_d;
      rearm_q      <= rearm_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    next_nline_d = next_nline_q;
    stride_d     = stride_q;
    nlines_d     = nlines_q;
    cnt_d        = cnt_q;
    rearm_d      = rearm_q;

    if (!en_i) begin
      state_d = IDLE;
    end else if (cfg_base_set_i) begin
      // Reloading the base abandons any burst in flight.
      base_d  = cfg_base_i;
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (snoop_match_i && (cfg_nlines_i != '0)) begin
            // Burst parameters are frozen here so cfg changes cannot
            // disturb the burst that follows.
            stride_d     = stride_ext;
            nlines_d     = cfg_nlines_i;
            rearm_d      = cfg_rearm_i;
            cnt_d        = '0;
            next_nline_d = base_q + stride_ext;
            state_d      = ISSUE;
          end
        end
        ISSUE: begin
          // valid is high throughout ISSUE, so ready alone is the handshake.
          if (req_if.req_ready) begin
            cnt_d        = cnt_q + NLINES_W'(1);
            next_nline_d = next_nline_q + stride_q;
            if (cnt_q == (nlines_q - NLINES_W'(1))) begin
              if (rearm_q) begin
                base_d  = next_nline_q;
                state_d = ARMED;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign snoop_en_o       = (state_q == ARMED);
  assign busy_o           = (state_q == ISSUE);
  assign req_if.req_valid = (state_q == ISSUE);
  assign req_if.req_nline = next_nline_q;
  assign base_nline_o     = base_q;

endmodule

// File: doc/hwpf_stride_req_gen.md
# hwpf_stride_req_gen

Stride prefetch request generator for the hardware prefetcher. It owns the base cache line that the stride snooper compares against and drives that snooper's enable. On a snoop match it issues a burst of prefetch cache-line requests at base + k·stride over a valid/ready handshake. After the burst it either rearms itself at the last prefetched line or returns to idle.

## Interface
Parameters:
- STRIDE_W, 16, width of the stride in cache lines.
- NLINES_W, 4, width of the lines-per-trigger count.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- en_i  in  1  engine enable; low forces IDLE
- cfg_base_set_i  in  1  load cfg_base_i as base and arm
- cfg_base_i  in  hpdcache_nline_t  new base cache line
- cfg_stride_i  in  STRIDE_W  stride in cache lines
- cfg_nlines_i  in  NLINES_W  lines per trigger
- cfg_rearm_i  in  1  after a burst, 1 = rearm at the last issued line, 0 = go IDLE
- snoop_match_i  in  1  match from snooper
- snoop_en_o  out  1  snooper enable
- base_nline_o  out  hpdcache_nline_t  base line for the snooper
- req_valid_o  out  1  prefetch request valid
- req_ready_i  in  1  prefetch request accepted
- req_nline_o  out  hpdcache_nline_t  prefetch cache line
- busy_o  out  1  burst in progress

## Operation
- States:
  - IDLE: snoop_en_o=0, req_valid_o=0.
  - ARMED: snoop_en_o=1.
  - ISSUE: req_valid_o=1, snoop_en_o=0, busy_o=1.
- Priority, highest first: rst_i, then en_i=0, then cfg_base_set_i, then FSM transitions.
- en_i=0 in any state: next state IDLE. Base is kept, and req_valid_o drops the next cycle.
- cfg_base_set_i=1 with en_i=1, in any state:
  - base <= cfg_base_i and next state is ARMED.
  - An in-flight burst is abandoned.
  - This and en_i=0 are the only cases where req_valid_o may drop without a handshake.
- ARMED with snoop_match_i=1:
  - cfg_nlines_i==0: the match is ignored and the FSM stays ARMED.
  - Otherwise, latch stride and nlines, set cnt <= 0 and next_nline <= base + stride, and go to ISSUE.
- ISSUE:
  - req_nline_o = next_nline.
  - On handshake (req_valid_o & req_ready_i), cnt increments and next_nline <= next_nline + stride.
  - On the handshake with cnt == nlines-1: if the latched rearm value is 1, base <= the line just issued and next state is ARMED; otherwise next state is IDLE.
- cfg_rearm_i is latched together with stride and nlines at trigger time. Changes to cfg_* during ISSUE have no effect on the current burst.
- snoop_match_i is ignored outside ARMED.
- req_nline_o and valid are stable while valid is high and ready is low.
- Arithmetic: nline addition is modulo 2^width(hpdcache_nline_t), so wrap-around is silent and not flagged.
- Stride extension: zero-extended to the nline width (see Configuration for the signed variant). A stride of 0 issues the base line nlines times.

## Timing
- Reset values:
  - state IDLE; base_nline_o = 0; req_nline_o = 0; next_nline = 0; cnt = 0.
  - snoop_en_o = 0; req_valid_o = 0; busy_o = 0.
- All outputs are registered or decoded from registered state; there is no combinational path from req_ready_i or snoop_match_i to any output.
- cfg_base_set_i at cycle t: base_nline_o is updated and snoop_en_o=1 at t+1.
- snoop_match_i at t in ARMED: req_valid_o=1 at t+1 with base+stride.
- With req_ready_i held at 1, one request is issued per cycle, so a burst of N lines takes N cycles.
- Last handshake at t:
  - With rearm: ARMED at t+1, with snoop_en_o=1 and the new base.
  - Without rearm: IDLE at t+1.
- Asynchronous reset mid-burst: outputs go to their reset values immediately; no partial request is held.

## Configuration
- HPDCACHE_HWPF_STRIDE_NEGATIVE_EN defined:
  - cfg_stride_i is two's complement and is sign-extended to the nline width, so backward streams are supported (e.g. 16'hFFFF = −1 line).
- Not defined:
  - cfg_stride_i is unsigned and zero-extended, so 16'hFFFF = +65535 lines.
- No other behaviour differs between the two builds.

## Test plan
- Basic burst:
  - Stimulus: base=0x100, stride=2, nlines=3, rearm=0, match, ready=1.
  - Response: requests 0x102, 0x104, 0x106 on three consecutive cycles, then IDLE with snoop_en_o=0.
- Rearm:
  - Stimulus: same setup with rearm=1.
  - Response: after the burst, base_nline_o=0x106 and snoop_en_o=1. A second match issues 0x108, 0x10A, 0x10C.
- Backpressure:
  - Stimulus: ready low for 4 cycles on the 2nd request.
  - Response: req_nline_o is held at 0x104 with valid high; no request is skipped or duplicated.
- Abort:
  - Stimulus: en_i deasserts mid-burst.
  - Response: req_valid_o=0 the next cycle and state is IDLE. A subsequent cfg_base_set_i rearms, and nlines=0 followed by a match issues nothing.
- Wrap:
  - Stimulus: base = all-ones, stride=1.
  - Response: the first request is 0.
  - With the macro and stride=16'hFFFF, base=0x100: requests are 0xFF, 0xFE.
  - Without the macro: the first request is 0x100+0xFFFF.
- Async reset:
  - Stimulus: rst_i asserted mid-burst while ready is low.
  - Response: all outputs go to reset values without waiting for a clock edge.
